// File: rtl/instruction_set_pkg.sv
// rtl/instruction_set_pkg.sv - shared ISA widths, opcode encoding and flag layout
//
// Purpose: single source of the datapath widths, the eOperation encoding and
// the sFlags layout used by the ALU and by everything that talks to it.
// Opcode 0 (OP_NOP) is the reset/idle encoding. Encodings 13..15 are reserved:
// the ALU returns '0 for them.
package InstructionSetPkg;

  localparam int DataWidth      = 16;
  localparam int ImmediateWidth = 8;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_MOVE = 4'd1,
    OP_ADD  = 4'd2,
    OP_ADC  = 4'd3,
    OP_SUB  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_MUL  = 4'd8,
    OP_MUH  = 4'd9,
    OP_DIV  = 4'd10,
    OP_MOD  = 4'd11,
    OP_LDI  = 4'd12
  } eOperation;

  typedef struct packed {
    logic zero;
    logic carry;
    logic parity;
  } sFlags;

endpackage

// File: rtl/alu_request_arbiter_if.sv
// rtl/alu_request_arbiter_if.sv - two-requester request/response bundle for the ALU arbiter
//
// Purpose: groups the per-requester request channel (valid/ready plus operand
// payload) and the response channel (per-owner valid/ready plus the shared
// result bus).
// Modports:
//   master : requester side; drives req_* payload, req_valid and rsp_ready
//   slave  : arbiter side; drives req_ready, rsp_valid, rsp_result,
//            rsp_flags and rsp_div_zero
interface alu_request_arbiter_if;

  logic [1:0]                                          req_valid;
  logic [1:0]                                          req_ready;
  InstructionSetPkg::eOperation                        req_op    [2];
  logic signed [InstructionSetPkg::DataWidth-1:0]      req_src   [2];
  logic signed [InstructionSetPkg::DataWidth-1:0]      req_dest  [2];
  logic signed [InstructionSetPkg::ImmediateWidth-1:0] req_imm   [2];
  InstructionSetPkg::sFlags                            req_flags [2];

  logic [1:0]                                          rsp_valid;
  logic [1:0]                                          rsp_ready;
  logic signed [InstructionSetPkg::DataWidth-1:0]      rsp_result;
  InstructionSetPkg::sFlags                            rsp_flags;
  logic                                                rsp_div_zero;

  modport master (
    output req_valid, req_op, req_src, req_dest, req_imm, req_flags, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_div_zero
  );

  modport slave (
    input  req_valid, req_op, req_src, req_dest, req_imm, req_flags, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_div_zero
  );

endinterface

// File: rtl/alu_request_arbiter.sv
// rtl/alu_request_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
//
// Purpose: grants one of two requesters (round robin on contention), latches
// its operands, holds them on the ALU inputs for a per-opcode number of cycles
// (long-path DIV/MOD/MUL/MUH get LongOpCycles), captures result and flags and
// returns them to the owner over a valid/ready response.
// Ports:
//   i_clk            : clock, rising edge
//   i_rst            : synchronous active-high reset
//   io_bus           : request/response bundle (slave side)
//   o_alu_operation  : opcode to the ALU
//   o_alu_in_flags   : flags to the ALU
//   o_alu_in_imm     : immediate to the ALU
//   o_alu_in_src     : source operand to the ALU
//   o_alu_in_dest    : destination operand to the ALU
//   i_alu_out_dest   : ALU result
//   i_alu_out_flags  : ALU output flags
module alu_request_arbiter
  import InstructionSetPkg::*;
#(
  parameter int LongOpCycles  = 4,
  parameter int ShortOpCycles = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  alu_request_arbiter_if.slave             io_bus,
  output eOperation                        o_alu_operation,
  output sFlags                            o_alu_in_flags,
  output logic signed [ImmediateWidth-1:0] o_alu_in_imm,
  output logic signed [DataWidth-1:0]      o_alu_in_src,
  output logic signed [DataWidth-1:0]      o_alu_in_dest,
  input  logic signed [DataWidth-1:0]      i_alu_out_dest,
  input  sFlags                            i_alu_out_flags
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LongLoad  = 4'(LongOpCycles - 1);
  localparam logic [3:0] ShortLoad = 4'(ShortOpCycles - 1);

  logic [1:0]                      r_state;
  logic                            r_last_grant;
  logic                            r_owner;
  logic [3:0]                      r_cnt;
  eOperation                       r_op;
  logic signed [DataWidth-1:0]     r_src;
  logic signed [DataWidth-1:0]     r_dest;
  logic signed [ImmediateWidth-1:0] r_imm;
  sFlags                           r_flags;
  logic signed [DataWidth-1:0]     r_result;
  sFlags                           r_rsp_flags;
  logic                            r_div_zero;

  logic      w_accept;
  logic      w_grant;
  logic      w_is_long;
  logic      w_div_zero;
  logic      w_rsp_done;
  eOperation w_grant_op;

  always_comb begin
    w_accept = (r_state == IDLE) && (|io_bus.req_valid);
    // On contention the requester that did not win last time goes next.
    if (&io_bus.req_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = io_bus.req_valid[1];
    end
    w_grant_op = io_bus.req_op[w_grant];
    w_is_long  = (w_grant_op == OP_DIV) || (w_grant_op == OP_MOD) ||
                 (w_grant_op == OP_MUL) || (w_grant_op == OP_MUH);
    // Zero divisor: the ALU output is meaningless, so it is replaced.
    w_div_zero = ((r_op == OP_DIV) || (r_op == OP_MOD)) && (r_src == '0);
    w_rsp_done = (r_state == RESP) && io_bus.rsp_ready[r_owner];
  end

  assign io_bus.req_ready    = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign io_bus.rsp_valid    = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign io_bus.rsp_result   = r_result;
  assign io_bus.rsp_flags    = r_rsp_flags;
  assign io_bus.rsp_div_zero = r_div_zero;

  // ALU inputs come only from the latched registers, so they hold still for
  // the whole EXEC window and keep their last value while idle.
  assign o_alu_operation = r_op;
  assign o_alu_in_flags  = r_flags;
  assign o_alu_in_imm    = r_imm;
  assign o_alu_in_src    = r_src;
  assign o_alu_in_dest   = r_dest;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_op         <= OP_NOP;
      r_src        <= '0;
      r_dest       <= '0;
      r_imm        <= '0;
      r_flags      <= '0;
      r_result     <= '0;
      r_rsp_flags  <= '0;
      r_div_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op         <= w_grant_op;
            r_src        <= io_bus.req_src[w_grant];
            r_dest       <= io_bus.req_dest[w_grant];
            r_imm        <= io_bus.req_imm[w_grant];
            r_flags      <= io_bus.req_flags[w_grant];
            r_owner      <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= w_is_long ? LongLoad : ShortLoad;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          if (r_cnt == 4'd0) begin
            if (w_div_zero) begin
              r_result    <= '0;
              r_rsp_flags <= r_flags;
              r_div_zero  <= 1'b1;
            end else begin
              r_result    <= i_alu_out_dest;
              r_rsp_flags <= i_alu_out_flags;
              r_div_zero  <= 1'b0;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (w_rsp_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb/tb_alu_request_arbiter.sv - self-checking bench for alu_request_arbiter with an ALU model and scoreboard
module tb_alu_request_arbiter;
  import InstructionSetPkg::*;

  localparam int LONG  = 4;
  localparam int SHORT = 1;

  typedef struct packed {
    logic [15:0] res;
    sFlags       fl;
  } alu_out_t;

  typedef struct {
    int          owner;
    logic [15:0] res;
    sFlags       fl;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t sb[$];
  int   grant_log[$];

  eOperation                 alu_op;
  sFlags                     alu_in_flags;
  logic signed [7:0]         alu_in_imm;
  logic signed [15:0]        alu_in_src;
  logic signed [15:0]        alu_in_dest;
  logic signed [15:0]        alu_out_dest;
  sFlags                     alu_out_flags;
  alu_out_t                  alu_o;

  alu_request_arbiter_if bus_if();

  alu_request_arbiter #(.LongOpCycles(LONG), .ShortOpCycles(SHORT)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .io_bus          (bus_if),
    .o_alu_operation (alu_op),
    .o_alu_in_flags  (alu_in_flags),
    .o_alu_in_imm    (alu_in_imm),
    .o_alu_in_src    (alu_in_src),
    .o_alu_in_dest   (alu_in_dest),
    .i_alu_out_dest  (alu_out_dest),
    .i_alu_out_flags (alu_out_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference combinational ALU; a zero divisor returns garbage on purpose.
  function automatic alu_out_t alu_model(eOperation op, logic signed [15:0] src,
                                         logic signed [15:0] dest, logic signed [7:0] imm,
                                         sFlags fin);
    alu_out_t          o;
    logic [16:0]       wide;
    logic signed [31:0] prod;
    logic              c;
    logic [15:0]       r;
    prod = dest * src;
    c    = fin.carry;
    r    = '0;
    case (op)
      OP_MOVE: r = src;
      OP_ADD:  begin wide = {1'b0, dest} + {1'b0, src}; r = wide[15:0]; c = wide[16]; end
      OP_ADC:  begin wide = {1'b0, dest} + {1'b0, src} + {16'd0, fin.carry}; r = wide[15:0]; c = wide[16]; end
      OP_SUB:  begin wide = {1'b0, dest} - {1'b0, src}; r = wide[15:0]; c = wide[16]; end
      OP_AND:  begin r = dest & src; c = 1'b0; end
      OP_OR:   begin r = dest | src; c = 1'b0; end
      OP_XOR:  begin r = dest ^ src; c = 1'b0; end
      OP_MUL:  r = prod[15:0];
      OP_MUH:  r = prod[31:16];
      OP_DIV:  r = (src == 0) ? 16'hDEAD : dest / src;
      OP_MOD:  r = (src == 0) ? 16'hDEAD : dest % src;
      OP_LDI:  r = {{8{imm[7]}}, imm};
      default: r = '0;
    endcase
    o.res       = r;
    o.fl.zero   = (r == 16'd0);
    o.fl.carry  = c;
    o.fl.parity = ~^r;
    if (((op == OP_DIV) || (op == OP_MOD)) && (src == 0)) o.fl = ~fin;
    if (op > OP_LDI) o.fl = '0;
    return o;
  endfunction

  always_comb alu_o = alu_model(alu_op, alu_in_src, alu_in_dest, alu_in_imm, alu_in_flags);
  assign alu_out_dest  = alu_o.res;
  assign alu_out_flags = alu_o.fl;

  // Scoreboard monitor: push on request handshake, pop and compare on response handshake.
  bit          prev_rsp_v = 1'b0;
  bit          prev_rst = 1'b1;
  bit          prev_acc = 1'b0;
  logic [46:0] drv_prev;
  logic [46:0] drv_now;
  exp_t        e;
  exp_t        n;
  alu_out_t    ao;
  eOperation   m_op;

  always @(negedge clk) begin
    drv_now = {alu_op, alu_in_src, alu_in_dest, alu_in_imm, alu_in_flags};
    if (rst) begin
      sb.delete();
      prev_rsp_v = 1'b0;
      prev_rst   = 1'b1;
      prev_acc   = 1'b0;
    end else begin
      if ((bus_if.rsp_valid != 2'b00) && !prev_rsp_v) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_rsp: rsp_valid=%b with nothing outstanding", bus_if.rsp_valid);
        end else if (cyc - sb[0].acc != sb[0].lat) begin
          errors++;
          $display("FAIL sb_latency: got %0d cycles, expected %0d", cyc - sb[0].acc, sb[0].lat);
        end
      end
      if ((bus_if.rsp_valid != 2'b00) && (sb.size() != 0)) begin
        e = sb[0];
        if (bus_if.rsp_ready[e.owner]) begin
          void'(sb.pop_front());
          checks++;
          if ({bus_if.rsp_valid, bus_if.rsp_result, bus_if.rsp_flags, bus_if.rsp_div_zero} !==
              {(e.owner == 1) ? 2'b10 : 2'b01, e.res, e.fl, e.dz}) begin
            errors++;
            $display("FAIL sb_response: got valid=%b res=%h fl=%b dz=%b, expected valid=%b res=%h fl=%b dz=%b",
                     bus_if.rsp_valid, bus_if.rsp_result, bus_if.rsp_flags, bus_if.rsp_div_zero,
                     (e.owner == 1) ? 2'b10 : 2'b01, e.res, e.fl, e.dz);
          end
        end
      end
      if (!prev_rst && !prev_acc) begin
        checks++;
        if (drv_now !== drv_prev) begin
          errors++;
          $display("FAIL alu_drive_stable: got %h, expected %h", drv_now, drv_prev);
        end
      end
      prev_acc = 1'b0;
      for (int g = 0; g < 2; g++) begin
        if (bus_if.req_valid[g] && bus_if.req_ready[g]) begin
          m_op = bus_if.req_op[g];
          if (((m_op == OP_DIV) || (m_op == OP_MOD)) && (bus_if.req_src[g] == 0)) begin
            n.res = '0;
            n.fl  = bus_if.req_flags[g];
            n.dz  = 1'b1;
          end else begin
            ao    = alu_model(m_op, bus_if.req_src[g], bus_if.req_dest[g], bus_if.req_imm[g], bus_if.req_flags[g]);
            n.res = ao.res;
            n.fl  = ao.fl;
            n.dz  = 1'b0;
          end
          n.owner = g;
          n.acc   = cyc;
          n.lat   = (m_op inside {OP_DIV, OP_MOD, OP_MUL, OP_MUH}) ? LONG + 1 : SHORT + 1;
          sb.push_back(n);
          grant_log.push_back(g);
          prev_acc = 1'b1;
        end
      end
      prev_rsp_v = (bus_if.rsp_valid != 2'b00);
      prev_rst   = 1'b0;
    end
    drv_prev = drv_now;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int g, input eOperation op, input logic [15:0] src,
                         input logic [15:0] dest, input logic [7:0] imm, input sFlags fl);
    bus_if.req_op[g]    = op;
    bus_if.req_src[g]   = src;
    bus_if.req_dest[g]  = dest;
    bus_if.req_imm[g]   = imm;
    bus_if.req_flags[g] = fl;
    bus_if.req_valid[g] = 1'b1;
  endtask

  task automatic send(input int g, input eOperation op, input logic [15:0] src,
                      input logic [15:0] dest, input logic [7:0] imm, input sFlags fl,
                      output int acc);
    set_req(g, op, src, dest, imm, fl);
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus_if.req_ready[g]) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: req%0d got no req_ready, expected one within 100 cycles", g);
    end
    @(posedge clk);
    #1 bus_if.req_valid[g] = 1'b0;
  endtask

  task automatic wait_rsp(input int g, output int rc);
    rc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus_if.rsp_valid[g]) begin
        rc = cyc;
        break;
      end
    end
    if (rc < 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: rsp_valid[%0d] got 0, expected 1 within 100 cycles", g);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if ((sb.size() == 0) && (bus_if.rsp_valid == 2'b00)) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_result, bus_if.rsp_flags, bus_if.rsp_div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b valid=%b res=%h fl=%b dz=%b, expected all 0",
               bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_result, bus_if.rsp_flags, bus_if.rsp_div_zero);
    end
    checks++;
    if ({alu_op, alu_in_src, alu_in_dest, alu_in_imm, alu_in_flags} !== '0) begin
      errors++;
      $display("FAIL reset_alu_drive: got op=%0d src=%h dest=%h imm=%h fl=%b, expected all 0",
               alu_op, alu_in_src, alu_in_dest, alu_in_imm, alu_in_flags);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_adc();
    int acc, rc;
    set_req(0, OP_ADC, 16'h0003, 16'h0004, 8'h00, sFlags'(3'b010));
    #1;
    checks++;
    if (bus_if.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL adc_ready_same_cycle: got %b, expected 01", bus_if.req_ready);
    end
    send(0, OP_ADC, 16'h0003, 16'h0004, 8'h00, sFlags'(3'b010), acc);
    wait_rsp(0, rc);
    checks++;
    if (rc - acc != 2) begin
      errors++;
      $display("FAIL adc_latency: got %0d, expected 2", rc - acc);
    end
    checks++;
    if ({bus_if.rsp_result, bus_if.rsp_flags} !== {16'h0008, 3'b000}) begin
      errors++;
      $display("FAIL adc_result: got %h/%b, expected 0008/000", bus_if.rsp_result, bus_if.rsp_flags);
    end
    drain();
  endtask

  task automatic test_round_robin();
    do_reset();
    grant_log.delete();
    bus_if.req_op[0]  = OP_MOVE; bus_if.req_src[0] = 16'h1111;
    bus_if.req_op[1]  = OP_MOVE; bus_if.req_src[1] = 16'h2222;
    bus_if.req_valid  = 2'b11;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (grant_log.size() >= 4) break;
    end
    bus_if.req_valid = 2'b00;
    checks++;
    if (grant_log.size() < 4) begin
      errors++;
      $display("FAIL rr_count: got %0d grants, expected 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grant_log[i] != (i % 2)) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, grant_log[i], i % 2);
        end
      end
    end
    drain();
  endtask

  task automatic test_long_div();
    int acc, rc;
    send(1, OP_DIV, 16'd7, 16'd100, 8'h00, sFlags'(3'b000), acc);
    for (int i = 0; i < LONG; i++) begin
      @(negedge clk);
      checks++;
      if ({alu_op, alu_in_src, alu_in_dest} !== {OP_DIV, 16'd7, 16'd100}) begin
        errors++;
        $display("FAIL div_hold[%0d]: got op=%0d src=%0d dest=%0d, expected 10/7/100", i, alu_op, alu_in_src, alu_in_dest);
      end
    end
    wait_rsp(1, rc);
    checks++;
    if ({rc - acc, bus_if.rsp_result, bus_if.rsp_div_zero} !== {32'd5, 16'd14, 1'b0}) begin
      errors++;
      $display("FAIL div_result: got lat=%0d res=%0d dz=%b, expected 5/14/0", rc - acc, bus_if.rsp_result, bus_if.rsp_div_zero);
    end
    drain();
  endtask

  task automatic test_div_zero();
    int acc, rc;
    send(0, OP_MOD, 16'd0, 16'd55, 8'h00, sFlags'(3'b110), acc);
    wait_rsp(0, rc);
    checks++;
    if ({rc - acc, bus_if.rsp_result, bus_if.rsp_flags, bus_if.rsp_div_zero} !== {32'd5, 16'd0, 3'b110, 1'b1}) begin
      errors++;
      $display("FAIL mod_zero: got lat=%0d res=%h fl=%b dz=%b, expected 5/0000/110/1",
               rc - acc, bus_if.rsp_result, bus_if.rsp_flags, bus_if.rsp_div_zero);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int acc, rc;
    bus_if.rsp_ready = 2'b10;
    send(0, OP_ADD, 16'd5, 16'd6, 8'h00, sFlags'(3'b000), acc);
    set_req(1, OP_XOR, 16'h00FF, 16'h0F0F, 8'h00, sFlags'(3'b000));
    wait_rsp(0, rc);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_result} !== {2'b00, 2'b01, 16'd11}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ready=%b valid=%b res=%0d, expected 00/01/11",
                 i, bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_result);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus_if.rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (bus_if.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL bp_release_cycle: got %b, expected 00", bus_if.req_ready);
    end
    @(negedge clk);
    checks++;
    if (bus_if.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_next_accept: got %b, expected 10", bus_if.req_ready);
    end
    @(posedge clk);
    #1 bus_if.req_valid[1] = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_exec();
    int acc, rc;
    send(0, OP_MUH, 16'h0010, 16'h4000, 8'h00, sFlags'(3'b000), acc);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_if.req_ready, bus_if.rsp_valid, bus_if.rsp_result, bus_if.rsp_flags, bus_if.rsp_div_zero,
         alu_op, alu_in_src, alu_in_dest, alu_in_imm, alu_in_flags} !== '0) begin
      errors++;
      $display("FAIL abort_reset_state: got valid=%b res=%h op=%0d src=%h dest=%h, expected all 0",
               bus_if.rsp_valid, bus_if.rsp_result, alu_op, alu_in_src, alu_in_dest);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.rsp_valid !== 2'b00) begin
        errors++;
        $display("FAIL abort_no_rsp[%0d]: got %b, expected 00", i, bus_if.rsp_valid);
      end
    end
    @(posedge clk);
    #1;
    send(0, OP_ADD, 16'd1, 16'd2, 8'h00, sFlags'(3'b000), acc);
    wait_rsp(0, rc);
    checks++;
    if ({rc - acc, bus_if.rsp_result} !== {32'd2, 16'd3}) begin
      errors++;
      $display("FAIL after_abort: got lat=%0d res=%0d, expected 2/3", rc - acc, bus_if.rsp_result);
    end
    drain();
  endtask

  initial begin
    bus_if.req_valid = 2'b00;
    bus_if.rsp_ready = 2'b11;
    for (int g = 0; g < 2; g++) begin
      bus_if.req_op[g]    = OP_NOP;
      bus_if.req_src[g]   = '0;
      bus_if.req_dest[g]  = '0;
      bus_if.req_imm[g]   = '0;
      bus_if.req_flags[g] = '0;
    end
    test_reset();
    test_single_adc();
    test_round_robin();
    test_long_div();
    test_div_zero();
    test_backpressure();
    test_reset_mid_exec();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
